// File: rtl/subword_store_unit.sv
// -----------------------------------------------------------------------------
// subword_store_unit
//
// Narrows a 32-bit register value to byte / halfword / word and writes it into
// a word-wide data memory. Word stores go straight to memory. Byte and halfword
// stores read the target word, merge the new lane(s) and write the word back.
// Misaligned or illegal requests finish with an error pulse and never touch
// memory.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   reset      in   synchronous, active-high reset
//   start      in   request strobe, only looked at in IDLE
//   size       in   2'b00 byte, 2'b01 halfword, 2'b10 word, 2'b11 illegal
//   addr       in   byte address of the store
//   wdata      in   register value; the low 8/16/32 bits are stored
//   busy       out  high whenever the unit is not idle
//   done       out  one-cycle completion pulse
//   err        out  qualifies done: request was rejected, memory untouched
//   mem_addr   out  word address, held from one accept to the next
//   mem_rd_en  out  one-cycle read strobe
//   mem_rdata  in   read data, valid RD_LAT cycles after mem_rd_en
//   mem_wr_en  out  one-cycle full-word write strobe
//   mem_wdata  out  word to write
// -----------------------------------------------------------------------------
module subword_store_unit #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          lane_q, lane_d;
  logic                half_q, half_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                bad_q, bad_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                req_bad;

  // Address bits above the memory window wrap by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Replace the addressed lane(s) of the old word; other lanes pass through.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [15:0] new_data,
                                              input logic [1:0]  lane,
                                              input logic        half);
    logic [31:0] word;
    word = old_word;
    if (half) word[{lane[1], 4'b0000} +: 16] = new_data;
    else      word[{lane, 3'b000} +: 8]      = new_data[7:0];
    return word;
  endfunction

  assign req_bad = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);

  // NOTE: every _d gets its _q value first so no path through this block
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    half_d      = half_q;
    wdata_d     = wdata_q;
    bad_d       = bad_q;
    cnt_d       = cnt_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = addr[ADDR_W+1:2];
          lane_d  = addr[1:0];
          half_d  = (size == 2'b01);
          wdata_d = wdata[15:0];
          bad_d   = req_bad;
          if (req_bad) begin
            state_d = DONE;
          end else if (size == 2'b10) begin
            // Full word: no read needed, the register value is the write data.
            mem_wdata_d = wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          mem_wdata_d = merge_lanes(mem_rdata, wdata_q, lane_q, half_q);
          state_d     = WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      lane_q      <= '0;
      half_q      <= 1'b0;
      wdata_q     <= '0;
      bad_q       <= 1'b0;
      cnt_q       <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      half_q      <= half_d;
      wdata_q     <= wdata_d;
      bad_q       <= bad_d;
      cnt_q       <= cnt_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Moore decodes of the state register.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && bad_q;
  assign mem_rd_en = (state_q == READ);
  assign mem_wr_en = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_subword_store_unit.sv
// -----------------------------------------------------------------------------
// tb_subword_store_unit
//
// Directed bench for subword_store_unit. Two instances share the clock and
// reset: dut1 with RD_LAT=1 and dut3 with RD_LAT=3, each with its own data
// memory model. Cycle numbers are counted from the accept edge T: cycle T+c is
// the clock period following the c-th edge after T.
// -----------------------------------------------------------------------------
module tb_subword_store_unit;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start1, start3;
  logic [1:0]    size;
  logic [31:0]   addr, wdata;

  logic          busy1, done1, err1, rd1, wr1;
  logic [AW-1:0] maddr1;
  logic [31:0]   rdata1, mwdata1;
  logic          busy3, done3, err3, rd3, wr3;
  logic [AW-1:0] maddr3;
  logic [31:0]   rdata3, mwdata3;

  subword_store_unit #(.ADDR_W(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy1), .done(done1), .err(err1), .mem_addr(maddr1),
    .mem_rd_en(rd1), .mem_rdata(rdata1), .mem_wr_en(wr1), .mem_wdata(mwdata1)
  );

  subword_store_unit #(.ADDR_W(AW), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy3), .done(done3), .err(err3), .mem_addr(maddr3),
    .mem_rd_en(rd3), .mem_rdata(rdata3), .mem_wr_en(wr3), .mem_wdata(mwdata3)
  );

  // Memory models: read data is X except exactly RD_LAT cycles after a read.
  logic [31:0]   mem1 [1024];
  logic [31:0]   mem3 [1024];
  logic [31:0]   p3a, p3b, p3c;
  logic          pre_we, pre_sel;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;

  always @(posedge clk) begin
    if (wr1) mem1[maddr1] <= mwdata1;
    if (wr3) mem3[maddr3] <= mwdata3;
    if (pre_we) begin
      if (pre_sel) mem3[pre_addr] <= pre_data;
      else         mem1[pre_addr] <= pre_data;
    end
    rdata1 <= rd1 ? mem1[maddr1] : 32'hx;
    p3a    <= rd3 ? mem3[maddr3] : 32'hx;
    p3b    <= p3a;
    p3c    <= p3b;
  end
  assign rdata3 = p3c;

  // Observation mux: which instance the current operation targets.
  logic          sel;
  logic          o_busy, o_done, o_err, o_rd, o_wr;
  logic [AW-1:0] o_maddr;
  logic [31:0]   o_mwdata;
  assign o_busy   = sel ? busy3   : busy1;
  assign o_done   = sel ? done3   : done1;
  assign o_err    = sel ? err3    : err1;
  assign o_rd     = sel ? rd3     : rd1;
  assign o_wr     = sel ? wr3     : wr1;
  assign o_maddr  = sel ? maddr3  : maddr1;
  assign o_mwdata = sel ? mwdata3 : mwdata1;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-operation observations.
  int            rd_cyc, wr_cyc, done_cyc, n_rd, n_wr, busy_n;
  logic [31:0]   wr_data;
  logic [AW-1:0] wr_addr;
  logic          err_at_done;

  logic [1:0]  bad_sz [3] = '{2'b01, 2'b10, 2'b11};
  logic [31:0] bad_ad [3] = '{32'h15, 32'h22, 32'h20};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic s, input logic [AW-1:0] a, input logic [31:0] d);
    pre_sel  = s;
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request and watch it up to max_cyc cycles or until done.
  // hold keeps start asserted throughout the operation.
  task automatic do_op(input logic s, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic hold, input int max_cyc);
    sel = s; size = sz; addr = a; wdata = wd;
    if (s) start3 = 1'b1; else start1 = 1'b1;
    rd_cyc = -1; wr_cyc = -1; done_cyc = -1;
    n_rd = 0; n_wr = 0; busy_n = 0;
    wr_data = 32'hx; wr_addr = 'x; err_at_done = 1'bx;
    @(posedge clk); #1;
    if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (o_rd)   begin n_rd++; rd_cyc = c; end
      if (o_wr)   begin n_wr++; wr_cyc = c; wr_data = o_mwdata; wr_addr = o_maddr; end
      if (o_busy) busy_n++;
      if (o_done) begin done_cyc = c; err_at_done = o_err; end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr_rst, n_done_rst;
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; sel = 1'b0;
    size = 2'b00; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_sel = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   busy1,   0);
    check("rst_done",   done1,   0);
    check("rst_err",    err1,    0);
    check("rst_rd",     rd1,     0);
    check("rst_wr",     wr1,     0);
    check("rst_maddr",  maddr1,  0);
    check("rst_mwdata", mwdata1, 0);
    check("rst_busy3",  busy3,   0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Byte store into lane 2 of word 5.
    preload(0, 5, 32'hAABBCCDD);
    do_op(0, 2'b00, 32'h16, 32'h123456EE, 0, 12);
    check("sb_rd_cyc",   rd_cyc,      1);
    check("sb_n_rd",     n_rd,        1);
    check("sb_wr_cyc",   wr_cyc,      3);
    check("sb_n_wr",     n_wr,        1);
    check("sb_wdata",    wr_data,     32'hAAEECCDD);
    check("sb_maddr",    wr_addr,     5);
    check("sb_done_cyc", done_cyc,    4);
    check("sb_err",      err_at_done, 0);
    check("sb_busy_n",   busy_n,      4);

    // Halfword stores, upper then lower half.
    preload(0, 5, 32'hAABBCCDD);
    do_op(0, 2'b01, 32'h16, 32'hFFFF1234, 0, 12);
    check("sh_hi_wdata", wr_data,  32'h1234CCDD);
    check("sh_hi_done",  done_cyc, 4);
    preload(0, 5, 32'hAABBCCDD);
    do_op(0, 2'b01, 32'h14, 32'hFFFF1234, 0, 12);
    check("sh_lo_wdata", wr_data,  32'hAABB1234);
    check("sh_lo_err",   err_at_done, 0);

    // Word store: direct write.
    do_op(0, 2'b10, 32'h20, 32'hDEADBEEF, 0, 12);
    check("sw_n_rd",     n_rd,     0);
    check("sw_wr_cyc",   wr_cyc,   1);
    check("sw_wdata",    wr_data,  32'hDEADBEEF);
    check("sw_maddr",    wr_addr,  8);
    check("sw_done_cyc", done_cyc, 2);
    check("sw_busy_n",   busy_n,   2);

    // Address bits above the memory window are ignored.
    do_op(0, 2'b10, 32'h1000_0020, 32'h0BADF00D, 0, 12);
    check("wrap_maddr", wr_addr, 8);
    check("wrap_wdata", wr_data, 32'h0BADF00D);

    // Misaligned and illegal requests.
    for (int i = 0; i < 3; i++) begin
      do_op(0, bad_sz[i], bad_ad[i], 32'h55555555, 0, 12);
      check($sformatf("bad%0d_done", i), done_cyc,    1);
      check($sformatf("bad%0d_err",  i), err_at_done, 1);
      check($sformatf("bad%0d_n_rd", i), n_rd,        0);
      check($sformatf("bad%0d_n_wr", i), n_wr,        0);
      check($sformatf("bad%0d_busy", i), busy_n,      1);
    end

    // start held high for a whole sb: exactly one write.
    preload(0, 5, 32'hAABBCCDD);
    do_op(0, 2'b00, 32'h16, 32'h123456EE, 1, 12);
    check("hold_n_wr", n_wr,     1);
    check("hold_done", done_cyc, 4);
    check("hold_idle", busy1,    0);
    do_op(0, 2'b10, 32'h24, 32'h12345678, 0, 12);
    check("after_hold_done",  done_cyc, 2);
    check("after_hold_maddr", wr_addr,  9);

    // Reset during WAIT of an sb.
    preload(0, 5, 32'hAABBCCDD);
    sel = 1'b0; size = 2'b00; addr = 32'h16; wdata = 32'h123456EE;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_in_wait", busy1, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy",  busy1,  0);
    check("rst_mid_maddr", maddr1, 0);
    n_wr_rst = 0; n_done_rst = 0;
    for (int c = 0; c < 5; c++) begin
      if (wr1)   n_wr_rst++;
      if (done1) n_done_rst++;
      @(negedge clk);
    end
    check("rst_mid_n_wr",   n_wr_rst,   0);
    check("rst_mid_n_done", n_done_rst, 0);
    @(posedge clk); #1;

    // Same byte store with RD_LAT=3.
    preload(1, 5, 32'hAABBCCDD);
    do_op(1, 2'b00, 32'h16, 32'h123456EE, 0, 16);
    check("lat3_rd_cyc", rd_cyc,   1);
    check("lat3_wr_cyc", wr_cyc,   5);
    check("lat3_wdata",  wr_data,  32'hAAEECCDD);
    check("lat3_done",   done_cyc, 6);
    check("lat3_busy_n", busy_n,   6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
